alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that serialises two requesters' commands onto one
// multi-cycle ALU, sequencing load/persist control and returning one tagged result.
module alu_arbiter #(
    parameter  int unsigned ALU_LAT = 2,
    localparam int unsigned OP_W    = 3,
    localparam int unsigned DATA_W  = 8,
    localparam int unsigned SEL_W   = 7,
    localparam int unsigned CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              on,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [2:0]        alu_in_sel,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    output logic [SEL_W-1:0]  alu_out_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    localparam logic [2:0]       IN_IDLE    = 3'b000;
    localparam logic [2:0]       IN_RST     = 3'b001;
    localparam logic [2:0]       IN_LOAD    = 3'b010;
    localparam logic [2:0]       IN_HOLD    = 3'b100;
    localparam logic [OP_W-1:0]  OP_ILLEGAL = 3'd7;
    localparam logic [SEL_W-1:0] SEL_TOP    = 7'b1000000;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic                r_last, w_last;
    logic                r_id, w_id;
    logic                r_resp_valid, w_resp_valid;
    logic                r_resp_id, w_resp_id;
    logic                r_resp_err, w_resp_err;
    logic [DATA_W-1:0]   r_resp_data, w_resp_data;
    logic [2:0]          r_in_sel, w_in_sel;
    logic [DATA_W-1:0]   r_num1, w_num1;
    logic [DATA_W-1:0]   r_num2, w_num2;
    logic [SEL_W-1:0]    r_out_sel, w_out_sel;

    logic                w_gnt_id;
    logic                w_can_grant;
    logic                w_accept;
    cmd_t                w_cmd;

    // Grant: a lone valid requester wins; on a tie, the one not granted last wins.
    always_comb begin
        w_gnt_id    = req1_valid & (~req0_valid | ~r_last);
        w_can_grant = (r_state == S_IDLE) && on;
        req0_ready  = w_can_grant && req0_valid && !w_gnt_id;
        req1_ready  = w_can_grant && req1_valid && w_gnt_id;
        w_accept    = req0_ready || req1_ready;
        w_cmd       = w_gnt_id ? cmd_t'{req1_op, req1_a, req1_b}
                               : cmd_t'{req0_op, req0_a, req0_b};
    end

    // Next state plus next value of every registered output.
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_last       = r_last;
        w_id         = r_id;
        w_resp_valid = 1'b0;
        w_resp_id    = r_resp_id;
        w_resp_err   = r_resp_err;
        w_resp_data  = r_resp_data;
        w_in_sel     = IN_IDLE;
        w_num1       = '0;
        w_num2       = '0;
        w_out_sel    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_last = w_gnt_id;
                    w_id   = w_gnt_id;
                    if (w_cmd.op == OP_ILLEGAL) begin
                        w_state      = S_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_id    = w_gnt_id;
                        w_resp_err   = 1'b1;
                        w_resp_data  = '0;
                    end else begin
                        w_state   = S_LOAD;
                        w_in_sel  = IN_LOAD;
                        w_num1    = w_cmd.a;
                        w_num2    = w_cmd.b;
                        w_out_sel = SEL_W'(SEL_TOP >> w_cmd.op);
                    end
                end
            end
            S_LOAD: begin
                w_state   = S_WAIT;
                w_cnt     = CNT_W'(ALU_LAT);
                w_in_sel  = IN_HOLD;
                w_num1    = r_num1;
                w_num2    = r_num2;
                w_out_sel = r_out_sel;
            end
            S_WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    // Last persist cycle: capture the ALU result on this edge.
                    w_state      = S_RESP;
                    w_cnt        = '0;
                    w_resp_valid = 1'b1;
                    w_resp_id    = r_id;
                    w_resp_err   = 1'b0;
                    w_resp_data  = alu_out;
                end else begin
                    w_cnt     = r_cnt - CNT_W'(1);
                    w_in_sel  = IN_HOLD;
                    w_num1    = r_num1;
                    w_num2    = r_num2;
                    w_out_sel = r_out_sel;
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the ALU in its reset control.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last       <= 1'b1;
            r_id         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
            r_in_sel     <= IN_RST;
            r_num1       <= '0;
            r_num2       <= '0;
            r_out_sel    <= '0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_last       <= w_last;
            r_id         <= w_id;
            r_resp_valid <= w_resp_valid;
            r_resp_id    <= w_resp_id;
            r_resp_err   <= w_resp_err;
            r_resp_data  <= w_resp_data;
            r_in_sel     <= w_in_sel;
            r_num1       <= w_num1;
            r_num2       <= w_num2;
            r_out_sel    <= w_out_sel;
        end
    end

    assign state       = r_state;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_err    = r_resp_err;
    assign resp_data   = r_resp_data;
    assign alu_in_sel  = r_in_sel;
    assign alu_num1    = r_num1;
    assign alu_num2    = r_num2;
    assign alu_out_sel = r_out_sel;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU plus a response
// scoreboard filled on acceptance and drained when resp_valid appears.
module tb_alu_arbiter;

    localparam int unsigned LAT = 2;

    logic       clk = 1'b0;
    logic       rst, on;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       resp_valid, resp_id, resp_err;
    logic [7:0] resp_data, alu_num1, alu_num2, alu_out;
    logic [2:0] alu_in_sel;
    logic [6:0] alu_out_sel;
    logic [1:0] state;

    typedef struct packed {
        logic       id;
        logic       err;
        logic [7:0] data;
    } resp_t;

    resp_t sb[$];
    int    n_cmp = 0;
    int    n_mis = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .on(on),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_out_sel(alu_out_sel), .alu_out(alu_out), .state(state)
    );

    // Behavioural ALU: result is xor'ed with the persist count so that sampling
    // in any cycle other than the last persist cycle gives a different value.
    function automatic logic [7:0] alu_f(input logic [6:0] sel, input logic [7:0] x, input logic [7:0] y);
        case (sel)
            7'b1000000: return x + y;
            7'b0100000: return x - y;
            7'b0010000: return x & y;
            7'b0001000: return x | y;
            7'b0000100: return x ^ y;
            7'b0000010: return ~x;
            7'b0000001: return y;
            default:    return 8'hEE;
        endcase
    endfunction

    function automatic logic [6:0] onehot(input logic [2:0] op);
        logic [6:0] t;
        t = 7'b1000000;
        return t >> op;
    endfunction

    function automatic logic [7:0] exp_data(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        return alu_f(onehot(op), x, y) ^ 8'(LAT - 1);
    endfunction

    logic [3:0] p_cnt;
    always_ff @(posedge clk) begin
        if (alu_in_sel == 3'b100) p_cnt <= p_cnt + 4'd1;
        else                      p_cnt <= 4'd0;
    end
    assign alu_out = alu_f(alu_out_sel, alu_num1, alu_num2) ^ {4'b0, p_cnt};

    task automatic wait_resp(input int budget, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc = i + 1;
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({state, resp_valid, resp_id, resp_err, resp_data, alu_in_sel, alu_num1, alu_num2, alu_out_sel}
            !== {2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 3'b001, 8'h00, 8'h00, 7'b0}) begin
            n_mis++;
            $display("FAIL reset_outputs: got st=%b rv=%b id=%b err=%b d=%h in=%b n1=%h n2=%h sel=%b",
                     state, resp_valid, resp_id, resp_err, resp_data, alu_in_sel, alu_num1, alu_num2, alu_out_sel);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({state, alu_in_sel} !== {2'b00, 3'b000}) begin
            n_mis++;
            $display("FAIL reset_release: got st=%b in=%b want st=00 in=000", state, alu_in_sel);
        end
    endtask

    task automatic test_single;
        resp_t e;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h57; req0_b = 8'h1A;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_mis++;
            $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
        end
        sb.push_back('{1'b0, 1'b0, exp_data(3'd0, 8'h57, 8'h1A)});
        @(negedge clk);
        req0_valid = 1'b0; req0_op = 3'd5; req0_a = 8'hFF; req0_b = 8'hFF;
        n_cmp++;
        if ({state, alu_in_sel, alu_num1, alu_num2, alu_out_sel} !== {2'b01, 3'b010, 8'h57, 8'h1A, 7'b1000000}) begin
            n_mis++;
            $display("FAIL single_load: got st=%b in=%b n1=%h n2=%h sel=%b want 01 010 57 1a 1000000",
                     state, alu_in_sel, alu_num1, alu_num2, alu_out_sel);
        end
        for (int k = 0; k < int'(LAT); k++) begin
            @(negedge clk);
            n_cmp++;
            if ({state, resp_valid, alu_in_sel, alu_num1, alu_num2, alu_out_sel}
                !== {2'b10, 1'b0, 3'b100, 8'h57, 8'h1A, 7'b1000000}) begin
                n_mis++;
                $display("FAIL single_wait%0d: got st=%b rv=%b in=%b n1=%h n2=%h sel=%b", k,
                         state, resp_valid, alu_in_sel, alu_num1, alu_num2, alu_out_sel);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({state, resp_valid} !== {2'b11, 1'b1} || sb.size() == 0) begin
            n_mis++;
            $display("FAIL single_resp_timing: got st=%b rv=%b want 11 1", state, resp_valid);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({resp_id, resp_err, resp_data} !== e) begin
                n_mis++;
                $display("FAIL single_resp_data: got id=%b err=%b d=%h want %h", resp_id, resp_err, resp_data, e);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({state, resp_valid, alu_in_sel} !== {2'b00, 1'b0, 3'b000}) begin
            n_mis++;
            $display("FAIL single_back_idle: got st=%b rv=%b in=%b", state, resp_valid, alu_in_sel);
        end
    endtask

    task automatic test_ops;
        resp_t      e;
        bit         seen;
        int         cyc;
        logic [7:0] a, b;
        logic       id;
        for (int op = 1; op <= 6; op++) begin
            @(negedge clk);
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            id = op[0];
            if (id) begin req1_valid = 1'b1; req1_op = 3'(op); req1_a = a; req1_b = b; end
            else    begin req0_valid = 1'b1; req0_op = 3'(op); req0_a = a; req0_b = b; end
            #1;
            n_cmp++;
            if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
                n_mis++;
                $display("FAIL ops_ready op%0d: got r1r0=%b", op, {req1_ready, req0_ready});
            end
            sb.push_back('{id, 1'b0, exp_data(3'(op), a, b)});
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            n_cmp++;
            if ({alu_out_sel, alu_num1, alu_num2} !== {onehot(3'(op)), a, b}) begin
                n_mis++;
                $display("FAIL ops_load op%0d: got sel=%b n1=%h n2=%h want %b %h %h",
                         op, alu_out_sel, alu_num1, alu_num2, onehot(3'(op)), a, b);
            end
            wait_resp(LAT + 4, seen, cyc);
            n_cmp++;
            if (!seen || cyc != int'(LAT) + 1 || sb.size() == 0) begin
                n_mis++;
                $display("FAIL ops_latency op%0d: got seen=%0d cyc=%0d want cyc=%0d", op, seen, cyc, LAT + 1);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if ({resp_id, resp_err, resp_data} !== e) begin
                    n_mis++;
                    $display("FAIL ops_resp op%0d: got id=%b err=%b d=%h want %h", op, resp_id, resp_err, resp_data, e);
                end
            end
        end
    endtask

    task automatic test_illegal;
        resp_t e;
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'd7; req1_a = 8'h33; req1_b = 8'h44;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready, alu_in_sel} !== {2'b10, 3'b000}) begin
            n_mis++;
            $display("FAIL illegal_ready: got r1r0=%b in=%b", {req1_ready, req0_ready}, alu_in_sel);
        end
        sb.push_back('{1'b1, 1'b1, 8'h00});
        @(negedge clk);
        req1_valid = 1'b0;
        n_cmp++;
        if ({state, resp_valid, alu_in_sel, alu_out_sel} !== {2'b11, 1'b1, 3'b000, 7'b0} || sb.size() == 0) begin
            n_mis++;
            $display("FAIL illegal_timing: got st=%b rv=%b in=%b sel=%b", state, resp_valid, alu_in_sel, alu_out_sel);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({resp_id, resp_err, resp_data} !== e) begin
                n_mis++;
                $display("FAIL illegal_resp: got id=%b err=%b d=%h want %h", resp_id, resp_err, resp_data, e);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({state, resp_valid} !== {2'b00, 1'b0}) begin
            n_mis++;
            $display("FAIL illegal_idle: got st=%b rv=%b", state, resp_valid);
        end
    endtask

    task automatic test_back_to_back;
        resp_t e;
        bit    seen;
        int    cyc;
        logic  exp_id, got;
        int    last_acc, n_acc;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h10; req0_b = 8'h20;
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'h90; req1_b = 8'h30;
        exp_id = 1'b0; last_acc = -1; n_acc = 0;
        for (int c = 0; c < 22; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                got = req1_ready;
                n_cmp++;
                if ({req1_ready, req0_ready} === 2'b11 || got !== exp_id) begin
                    n_mis++;
                    $display("FAIL b2b_grant%0d: got r1r0=%b want id %b", n_acc, {req1_ready, req0_ready}, exp_id);
                end
                if (last_acc >= 0) begin
                    n_cmp++;
                    if (c - last_acc != int'(LAT) + 3) begin
                        n_mis++;
                        $display("FAIL b2b_spacing%0d: got %0d want %0d", n_acc, c - last_acc, LAT + 3);
                    end
                end
                if (got) sb.push_back('{1'b1, 1'b0, exp_data(3'd1, 8'h90, 8'h30)});
                else     sb.push_back('{1'b0, 1'b0, exp_data(3'd0, 8'h10, 8'h20)});
                last_acc = c;
                exp_id   = ~exp_id;
                n_acc++;
            end
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL b2b_unexpected_resp: got id=%b d=%h want none", resp_id, resp_data);
                end else begin
                    e = sb.pop_front();
                    if ({resp_id, resp_err, resp_data} !== e) begin
                        n_mis++;
                        $display("FAIL b2b_resp: got id=%b err=%b d=%h want %h", resp_id, resp_err, resp_data, e);
                    end
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(LAT + 4, seen, cyc);
        n_cmp++;
        if (!seen || sb.size() != 1) begin
            n_mis++;
            $display("FAIL b2b_drain: got seen=%0d pending=%0d want 1 1", seen, sb.size());
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({resp_id, resp_err, resp_data} !== e) begin
                n_mis++;
                $display("FAIL b2b_last_resp: got id=%b err=%b d=%h want %h", resp_id, resp_err, resp_data, e);
            end
        end
        n_cmp++;
        if (n_acc != 5) begin
            n_mis++;
            $display("FAIL b2b_count: got %0d accepts want 5", n_acc);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid;
        int stray;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 8'hF0; req0_b = 8'h3C;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b10) begin
            n_mis++;
            $display("FAIL rstmid_in_wait: got st=%b want 10", state);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({state, resp_valid, alu_in_sel} !== {2'b00, 1'b0, 3'b001}) begin
                n_mis++;
                $display("FAIL rstmid_held%0d: got st=%b rv=%b in=%b want 00 0 001", k, state, resp_valid, alu_in_sel);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({state, alu_in_sel} !== {2'b00, 3'b000}) begin
            n_mis++;
            $display("FAIL rstmid_release: got st=%b in=%b want 00 000", state, alu_in_sel);
        end
        stray = 0;
        for (int k = 0; k < int'(LAT) + 3; k++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_mis++;
            $display("FAIL rstmid_no_resp: got %0d responses want 0", stray);
        end
    endtask

    task automatic test_on_gate;
        resp_t e;
        bit    seen;
        int    cyc;
        @(negedge clk);
        on = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd3; req0_a = 8'hA5; req0_b = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if ({req0_ready, state, alu_in_sel} !== {1'b0, 2'b00, 3'b000}) begin
                n_mis++;
                $display("FAIL on_gate%0d: got rdy=%b st=%b in=%b want 0 00 000", k, req0_ready, state, alu_in_sel);
            end
            @(negedge clk);
        end
        on = 1'b1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL on_raise_ready: got %b want 1", req0_ready);
        end
        sb.push_back('{1'b0, 1'b0, exp_data(3'd3, 8'hA5, 8'h0F)});
        @(negedge clk);
        on = 1'b0;
        n_cmp++;
        if (state !== 2'b01) begin
            n_mis++;
            $display("FAIL on_accept: got st=%b want 01", state);
        end
        wait_resp(LAT + 4, seen, cyc);
        n_cmp++;
        if (!seen || cyc != int'(LAT) + 1 || sb.size() == 0) begin
            n_mis++;
            $display("FAIL on_drop_resp: got seen=%0d cyc=%0d want cyc=%0d", seen, cyc, LAT + 1);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({resp_id, resp_err, resp_data} !== e) begin
                n_mis++;
                $display("FAIL on_drop_data: got id=%b err=%b d=%h want %h", resp_id, resp_err, resp_data, e);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({state, req0_ready, resp_valid} !== {2'b00, 1'b0, 1'b0}) begin
                n_mis++;
                $display("FAIL on_stay_idle%0d: got st=%b rdy=%b rv=%b", k, state, req0_ready, resp_valid);
            end
        end
        req0_valid = 1'b0;
        on = 1'b1;
    endtask

    initial begin
        rst = 1'b0; on = 1'b1;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00;
        test_reset;
        test_single;
        test_ops;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        test_on_gate;
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_empty: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
